// File: rtl/port_alloc_rr.sv
// Output-port allocator for the 5-port mesh router: per-output round-robin
// arbitration over lowest-bit targets, gated by per-output downstream credits.
module port_alloc_rr #(
  parameter int NUM_PORT         = 5,
  parameter int WIDTH_PV         = 5,
  parameter int CREDIT_DEPTH     = 4,
  parameter int WIDTH_CREDIT     = 3,
  parameter bit LOCAL_INF_CREDIT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORT-1:0]          req_valid,
  input  logic [NUM_PORT*WIDTH_PV-1:0] req_pv,
  input  logic [NUM_PORT-1:0]          credit_return,
  output logic [NUM_PORT-1:0]          gnt,
  output logic [NUM_PORT-1:0]          out_valid,
  output logic [NUM_PORT*3-1:0]        out_sel,
  output logic [NUM_PORT-1:0]          credit_avail,
  output logic                         err_credit_ovf
);

  localparam int SEL_W = 3;
  localparam logic [WIDTH_CREDIT-1:0] CNT_FULL = WIDTH_CREDIT'(CREDIT_DEPTH);

  genvar gi;

  logic [WIDTH_PV-1:0]       tgt_oh [NUM_PORT];
  logic [SEL_W-1:0]          ptr_q  [NUM_PORT];
  logic [SEL_W-1:0]          ptr_d  [NUM_PORT];
  logic [NUM_PORT-1:0]       gnt_c;
  logic [NUM_PORT-1:0]       ov_c;
  logic [NUM_PORT*SEL_W-1:0] sel_c;
  logic [NUM_PORT-1:0]       credit_avail_c;
  logic [NUM_PORT-1:0]       ovf_hit;
  logic                      err_q;

  // Isolate the lowest set bit: x & -x gives a one-hot target (or zero).
  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_tgt
      assign tgt_oh[gi] = req_pv[gi*WIDTH_PV +: WIDTH_PV]
                        & (~req_pv[gi*WIDTH_PV +: WIDTH_PV] + WIDTH_PV'(1));
    end
  endgenerate

  always_comb begin
    int   idx;
    logic done;
    gnt_c = '0;
    ov_c  = '0;
    sel_c = '0;
    idx   = 0;
    done  = 1'b0;
    for (int o = 0; o < NUM_PORT; o++) begin
      done     = 1'b0;
      ptr_d[o] = ptr_q[o];
      for (int k = 0; k < NUM_PORT; k++) begin
        idx = int'(ptr_q[o]) + k;
        if (idx >= NUM_PORT) idx = idx - NUM_PORT;
        if (!done && req_valid[idx] && tgt_oh[idx][o] && credit_avail_c[o]) begin
          done                       = 1'b1;
          gnt_c[idx]                 = 1'b1;
          ov_c[o]                    = 1'b1;
          sel_c[o*SEL_W +: SEL_W]    = SEL_W'(idx);
          ptr_d[o]                   = (idx == NUM_PORT-1) ? '0 : SEL_W'(idx + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int o = 0; o < NUM_PORT; o++) ptr_q[o] <= '0;
    end else begin
      for (int o = 0; o < NUM_PORT; o++) ptr_q[o] <= ptr_d[o];
    end
  end

  generate
    for (gi = 0; gi < NUM_PORT; gi++) begin : g_out
      if (LOCAL_INF_CREDIT && (gi == NUM_PORT-1)) begin : g_inf
        logic unused_ret;
        assign unused_ret         = credit_return[gi];
        assign credit_avail_c[gi] = 1'b1;
        assign ovf_hit[gi]        = 1'b0;
      end else begin : g_cnt
        logic [WIDTH_CREDIT-1:0] cnt_q;
        logic [WIDTH_CREDIT-1:0] cnt_d;

        // A return against a full counter with no grant to absorb it is an overflow.
        assign ovf_hit[gi]        = credit_return[gi] & ~ov_c[gi] & (cnt_q == CNT_FULL);
        assign credit_avail_c[gi] = (cnt_q != '0);

        always_comb begin
          cnt_d = cnt_q;
          if (credit_return[gi] && !ov_c[gi]) begin
            if (cnt_q != CNT_FULL) cnt_d = cnt_q + WIDTH_CREDIT'(1);
          end else if (!credit_return[gi] && ov_c[gi]) begin
            cnt_d = cnt_q - WIDTH_CREDIT'(1);
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) cnt_q <= CNT_FULL;
          else          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      err_q <= 1'b0;
    else if (|ovf_hit) err_q <= 1'b1;
  end

  assign gnt            = reset_n ? gnt_c : '0;
  assign out_valid      = reset_n ? ov_c  : '0;
  assign out_sel        = reset_n ? sel_c : '0;
  assign credit_avail   = credit_avail_c;
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_port_alloc_rr.sv
// Scoreboard bench for port_alloc_rr: each cycle's expected grant picture is
// queued when the stimulus is applied and compared at the following negedge.
module tb_port_alloc_rr;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [4:0]  req_valid = '0;
  logic [24:0] req_pv = '0;
  logic [4:0]  credit_return = '0;
  logic [4:0]  gnt, out_valid, credit_avail;
  logic [14:0] out_sel;
  logic        err_credit_ovf;

  typedef struct packed {
    logic [4:0]  gnt;
    logic [4:0]  ov;
    logic [14:0] sel;
    logic [4:0]  ca;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  port_alloc_rr dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_pv(req_pv),
    .credit_return(credit_return), .gnt(gnt), .out_valid(out_valid),
    .out_sel(out_sel), .credit_avail(credit_avail), .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t mk(input logic [4:0] g, input logic [4:0] ov,
                              input logic [14:0] sel, input logic [4:0] ca);
    exp_t r;
    r.gnt = g; r.ov = ov; r.sel = sel; r.ca = ca;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [4:0] pv);
    req_valid[i]     = 1'b1;
    req_pv[i*5 +: 5] = pv;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_pv = '0; credit_return = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) set_req(i, 5'b00010);
    sb.push_back(mk(5'b0, 5'b0, 15'h0, 5'b11111));
    @(negedge clk);
    e = sb.pop_front(); total++;
    if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
      bad++;
      $display("FAIL reset_hold: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
               gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
    end
    total++;
    if (err_credit_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0", err_credit_ovf);
    end
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.push_back(mk(5'b00001, 5'b00010, 15'h0, 5'b11111));
    @(negedge clk);
    e = sb.pop_front(); total++;
    if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
      bad++;
      $display("FAIL reset_first: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
               gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    int w[6] = '{0, 1, 3, 0, 1, 3};
    do_reset();
    set_req(0, 5'b00010); set_req(1, 5'b00010); set_req(3, 5'b00010);
    credit_return = 5'b00010;
    for (int c = 0; c < 6; c++) begin
      sb.push_back(mk(5'(1 << w[c]), 5'b00010, 15'(w[c] << 3), 5'b11111));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
        bad++;
        $display("FAIL rr c%0d: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
                 c, gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_credit_exhaust();
    logic g;
    do_reset();
    set_req(2, 5'b00001);
    for (int c = 0; c < 9; c++) begin
      credit_return = (c == 6) ? 5'b00001 : 5'b00000;
      g = (c < 4) || (c == 7);
      sb.push_back(mk(g ? 5'b00100 : 5'b0, g ? 5'b00001 : 5'b0, g ? 15'd2 : 15'd0,
                      (c < 4 || c == 7) ? 5'b11111 : 5'b11110));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
        bad++;
        $display("FAIL exhaust c%0d: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
                 c, gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_grant_and_return();
    logic g;
    do_reset();
    set_req(2, 5'b00001);
    for (int c = 0; c < 6; c++) begin
      credit_return = (c == 3) ? 5'b00001 : 5'b00000;
      g = (c < 5);
      sb.push_back(mk(g ? 5'b00100 : 5'b0, g ? 5'b00001 : 5'b0, g ? 15'd2 : 15'd0,
                      (c < 5) ? 5'b11111 : 5'b11110));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
        bad++;
        $display("FAIL simul c%0d: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
                 c, gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_local();
    do_reset();
    for (int i = 0; i < 5; i++) set_req(i, 5'b10000);
    for (int c = 0; c < 10; c++) begin
      credit_return = (c == 3) ? 5'b10000 : 5'b00000;
      sb.push_back(mk(5'(1 << (c % 5)), 5'b10000, 15'((c % 5) << 12), 5'b11111));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
        bad++;
        $display("FAIL local c%0d: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
                 c, gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
      end
      @(posedge clk); #1;
    end
    total++;
    if (err_credit_ovf !== 1'b0) begin
      bad++;
      $display("FAIL local_err: got %b want 0", err_credit_ovf);
    end
  endtask

  task automatic test_err_multihot();
    do_reset();
    credit_return = 5'b00100;
    sb.push_back(mk(5'b0, 5'b0, 15'h0, 5'b11111));
    @(negedge clk);
    e = sb.pop_front(); total++;
    if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
      bad++;
      $display("FAIL ovf_cycle: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
               gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
    end
    @(posedge clk); #1;
    credit_return = '0;
    total++;
    if (err_credit_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b want 1", err_credit_ovf);
    end
    set_req(0, 5'b00100); set_req(1, 5'b00110); set_req(3, 5'b00000);
    for (int c = 0; c < 5; c++) begin
      if (c < 4) sb.push_back(mk(5'b00011, 5'b00110, 15'd8, 5'b11111));
      else       sb.push_back(mk(5'b0, 5'b0, 15'h0, 5'b11001));
      @(negedge clk);
      e = sb.pop_front(); total++;
      if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
        bad++;
        $display("FAIL multihot c%0d: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
                 c, gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
      end
      @(posedge clk); #1;
    end
    total++;
    if (err_credit_ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_sticky: got %b want 1", err_credit_ovf);
    end
  endtask

  task automatic test_async_reset();
    set_req(4, 5'b10000);
    sb.push_back(mk(5'b10000, 5'b10000, 15'(4 << 12), 5'b11001));
    sb.push_back(mk(5'b0, 5'b0, 15'h0, 5'b11111));
    @(negedge clk);
    e = sb.pop_front(); total++;
    if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
      bad++;
      $display("FAIL async_pre: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
               gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
    end
    #2 reset_n = 1'b0;
    #1;
    e = sb.pop_front(); total++;
    if ({gnt, out_valid, out_sel, credit_avail} !== e) begin
      bad++;
      $display("FAIL async_mid: got gnt=%b ov=%b sel=%h ca=%b want gnt=%b ov=%b sel=%h ca=%b",
               gnt, out_valid, out_sel, credit_avail, e.gnt, e.ov, e.sel, e.ca);
    end
    total++;
    if (err_credit_ovf !== 1'b0) begin
      bad++;
      $display("FAIL async_err: got %b want 0", err_credit_ovf);
    end
    @(posedge clk); #1;
    clear_inputs();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_exhaust();
    test_grant_and_return();
    test_local();
    test_err_multihot();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/port_alloc_rr.md
# port_alloc_rr

Output-port allocator for the 5-port mesh router. It sits between the per-input route computation stage and the crossbar. Each cycle it takes every input's preferred-port vector and grants at most one input per output port. Arbitration is round-robin per output, and downstream buffer space is tracked with per-output credit counters.

## Interface
Parameters:
- `NUM_PORT`, 5: number of router ports. Port order is N=0, E=1, S=2, W=3, Local=4.
- `WIDTH_PV`, 5: width of one preferred-port vector. Must equal `NUM_PORT`.
- `CREDIT_DEPTH`, 4: downstream buffer slots per output, and the credit counter reset value.
- `WIDTH_CREDIT`, 3: counter width. Must hold `CREDIT_DEPTH`.
- `LOCAL_INF_CREDIT`, 1: when 1, output 4 (ejection) ignores credits and never blocks.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  router clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  `NUM_PORT`  input i holds a head flit.
- `req_pv`  in  `NUM_PORT*WIDTH_PV`  preferred-port vector of input i, in bits [i*5 +: 5].
- `credit_return`  in  `NUM_PORT`  one-cycle pulse: downstream of output o freed one slot.
- `gnt`  out  `NUM_PORT`  input i granted this cycle. Acts as the pop strobe for its flit.
- `out_valid`  out  `NUM_PORT`  output o is driven this cycle.
- `out_sel`  out  `NUM_PORT*3`  index of the input driving output o, in bits [o*3 +: 3].
- `credit_avail`  out  `NUM_PORT`  (cnt[o] > 0), or infinite-credit port.
- `err_credit_ovf`  out  1  sticky flag: a credit was returned while the counter was full.

## Operation
- Target selection per input: the target is the lowest set bit of `req_pv[i]`.
  - A zero vector means no request.
  - Multi-hot vectors are legal; only the lowest bit is used.
- Eligibility: input i is a candidate for output o when all of the following hold:
  - `req_valid[i]` is high.
  - Its target is o.
  - `credit_avail[o]` is high.
- Output arbitration: each output o keeps a pointer `ptr[o]` in 0..`NUM_PORT`-1.
  - Candidates are searched starting at `ptr[o]`, ascending with wrap-around.
  - The first candidate found wins.
- Input-side conflicts cannot occur, because each input targets exactly one output.
- Grant outputs are combinational from the current-cycle requests and registered state:
  - `gnt[i]=1` for the winning input.
  - `out_valid[o]=1` for an output with a winner.
  - `out_sel[o]` = index of the winner; 0 when `out_valid[o]=0`.
- Pointer update at the clock edge:
  - Grant to input i on output o: `ptr[o] <= (i+1) mod NUM_PORT`. From i=4 this wraps to 0.
  - No grant: the pointer holds.
- Credit update per output at the clock edge: `cnt[o] <= cnt[o] + credit_return[o] - out_valid[o]`.
  - Grant and return in the same cycle: net change is 0.
  - A grant is impossible at cnt=0, so the counter never underflows.
  - Return with cnt=`CREDIT_DEPTH` and no grant: the counter stays at `CREDIT_DEPTH` and `err_credit_ovf` is set. The flag clears only on reset.
  - Output 4 with `LOCAL_INF_CREDIT=1`: the counter is not updated, `credit_avail[4]` is always 1, and returns on port 4 are ignored without raising an error.
- Requester contract:
  - A flit stays valid with an unchanged `req_pv` until it is granted.
  - `gnt[i]` pops the flit in the same cycle.
  - The next flit may be presented in the following cycle.

## Timing
- Reset (`reset_n` low, asynchronous):
  - `cnt[o]=CREDIT_DEPTH`, `ptr[o]=0`, `err_credit_ovf=0`.
  - `gnt`, `out_valid` and `out_sel` are forced to 0 while reset is asserted, regardless of requests.
  - `credit_avail` = all ones.
- Reset asserted mid-operation: any in-flight grant that cycle is discarded, and all state returns to the reset values immediately.
- Request to grant latency: 0 cycles (combinational).
- Credit and pointer effects are visible in the cycle after the edge.
- A credit returned in cycle t can enable a grant in cycle t+1, not in cycle t.
- Throughput: up to one grant per output per cycle, and up to `NUM_PORT` grants per cycle in total.

## Test plan
- Reset behaviour: drive `reset_n=0` while all inputs request output 1 -> `gnt=0`, `out_valid=0`, `credit_avail=5'b11111`. After release, the first cycle grants input 0 on output 1.
- Round-robin and wrap: inputs 0, 1 and 3 hold `req_pv=5'b00010`, with `credit_return[1]=1` every cycle -> grants go to 0, 1, 3, 0, 1, 3 on consecutive cycles, and `out_sel[1]` follows 0, 1, 3.
- Credit exhaustion: input 2 continuously requests `5'b00001` with no returns -> 4 grants in cycles 0-3, then `credit_avail[0]=0` and no grant. A `credit_return[0]` pulse in cycle 6 -> grant in cycle 7.
- Simultaneous grant and return at cnt=1 -> grant issued, cnt stays 1, and the grant repeats next cycle.
- Local ejection: all 5 inputs request `5'b10000` for 10 cycles -> one grant per cycle in rotation 0, 1, 2, 3, 4, 0, …, with no stall.
- Error and multi-hot cases:
  - Return on output 2 at cnt=4 -> `err_credit_ovf=1` (sticky) and cnt stays 4.
  - `req_pv=5'b00110` -> input granted on output 1.
  - `req_pv=0` with `req_valid=1` -> never granted.
